// File: rtl/alu_defs.sv
// ALU opcode constants shared by the execute stage, plus the divider state encoding.
// Pure definitions; no logic, no latency.
package alu_defs;
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_XOR  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;
   localparam logic [2:0] ALU_AND  = 3'd4;
   localparam logic [2:0] ALU_NAND = 3'd5;
   localparam logic [2:0] ALU_NOR  = 3'd6;
   localparam logic [2:0] ALU_OR   = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_NEG_Q, S_NEG_R, S_DONE
   } div_state_t;
endpackage

// File: rtl/alu.sv
// Combinational 8-op ALU; zero latency, no flow control.
// carryout is the adder carry for ADD/SUB (1 on SUB means no borrow), else 0.
module ALU
   import alu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       command,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic [WIDTH-1:0] result,
   output logic             carryout
);
   logic             sub;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic             slt;

   always_comb begin
      sub = (command == ALU_SUB) || (command == ALU_SLT);
      sum = {1'b0, operandA} + {1'b0, (sub ? ~operandB : operandB)} + {{WIDTH{1'b0}}, sub};
      ovf = (operandA[WIDTH-1] ^ operandB[WIDTH-1]) & (operandA[WIDTH-1] ^ sum[WIDTH-1]);
      slt = sum[WIDTH-1] ^ ovf;
      carryout = 1'b0;
      result   = '0;
      case (command)
         ALU_ADD, ALU_SUB: begin
            result   = sum[WIDTH-1:0];
            carryout = sum[WIDTH];
         end
         ALU_XOR:  result = operandA ^ operandB;
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
         ALU_AND:  result = operandA & operandB;
         ALU_NAND: result = ~(operandA & operandB);
         ALU_NOR:  result = ~(operandA | operandB);
         default:  result = operandA | operandB;
      endcase
   end
endmodule

// File: rtl/mips_divider_unit.sv
// Standalone divider: mips_divider paired with its own private ALU.
// Same 37-cycle latency and busy/start behaviour as the bare divider.
module mips_divider_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic [2:0]       alu_command;
   logic [WIDTH-1:0] alu_operand_a, alu_operand_b, alu_result;
   logic             alu_carryout;

   mips_divider #(.WIDTH(WIDTH)) u_div (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .is_signed     (is_signed),
      .dividend      (dividend),
      .divisor       (divisor),
      .busy          (busy),
      .done          (done),
      .div_by_zero   (div_by_zero),
      .quotient      (quotient),
      .remainder     (remainder),
      .alu_command   (alu_command),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_result    (alu_result),
      .alu_carryout  (alu_carryout)
   );

   ALU #(.WIDTH(WIDTH)) u_alu (
      .command  (alu_command),
      .operandA (alu_operand_a),
      .operandB (alu_operand_b),
      .result   (alu_result),
      .carryout (alu_carryout)
   );
endmodule

// File: rtl/mips_divider.sv
// DIV/DIVU restoring divider driving the shared ALU; fixed 37-cycle start-to-done latency.
// busy stalls the pipeline; start is ignored unless idle or in the done cycle.
module mips_divider
   import alu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic [2:0]       alu_command,
   output logic [WIDTH-1:0] alu_operand_a,
   output logic [WIDTH-1:0] alu_operand_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout
);
   localparam int CNT_W = $clog2(WIDTH);

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] q_q, b_q, rem_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic             sgn_q, q_neg_q, r_neg_q, dbz_q;
   logic             busy_q, done_q, dbz_out_q;

   logic [WIDTH-1:0] shifted;
   logic             accept;
   logic [WIDTH-1:0] rem_d, q_d;

   // Dividend bits shift out of q_q's top while quotient bits fill from the bottom.
   assign shifted = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign accept  = rem_q[WIDTH-1] | alu_carryout;
   assign rem_d   = accept ? alu_result : shifted;
   assign q_d     = {q_q[WIDTH-2:0], accept};

   always_comb begin
      alu_command   = ALU_ADD;
      alu_operand_a = '0;
      alu_operand_b = '0;
      case (state_q)
         S_ABS_A: begin
            if (sgn_q && q_q[WIDTH-1]) begin
               alu_command   = ALU_SUB;
               alu_operand_b = q_q;
            end else alu_operand_a = q_q;
         end
         S_ABS_B: begin
            if (sgn_q && b_q[WIDTH-1]) begin
               alu_command   = ALU_SUB;
               alu_operand_b = b_q;
            end else alu_operand_a = b_q;
         end
         S_ITER: begin
            alu_command   = ALU_SUB;
            alu_operand_a = shifted;
            alu_operand_b = b_q;
         end
         S_NEG_Q: begin
            if (q_neg_q) begin
               alu_command   = ALU_SUB;
               alu_operand_b = q_q;
            end else alu_operand_a = q_q;
         end
         S_NEG_R: begin
            if (r_neg_q) begin
               alu_command   = ALU_SUB;
               alu_operand_b = rem_q;
            end else alu_operand_a = rem_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         q_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         sgn_q       <= 1'b0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_out_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_ABS_A;
                  busy_q  <= 1'b1;
                  q_q     <= dividend;
                  b_q     <= divisor;
                  rem_q   <= '0;
                  sgn_q   <= is_signed;
                  // A zero divisor leaves the all-ones quotient un-negated.
                  q_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & (divisor != '0);
                  r_neg_q <= is_signed & dividend[WIDTH-1];
                  dbz_q   <= (divisor == '0);
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ABS_A: begin
               q_q     <= alu_result;
               state_q <= S_ABS_B;
            end
            S_ABS_B: begin
               b_q     <= alu_result;
               cnt_q   <= '0;
               state_q <= S_ITER;
            end
            S_ITER: begin
               rem_q <= rem_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) state_q <= S_NEG_Q;
            end
            S_NEG_Q: begin
               q_q     <= alu_result;
               state_q <= S_NEG_R;
            end
            S_NEG_R: begin
               quotient_q  <= q_q;
               remainder_q <= alu_result;
               dbz_out_q   <= dbz_q;
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
endmodule

// File: tb/tb_mips_divider.sv
// Directed bench for mips_divider with a behavioural ADD/SUB ALU attached.
module tb_mips_divider;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend, divisor;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;
   logic [2:0]  alu_command;
   logic [31:0] alu_operand_a, alu_operand_b, alu_result;
   logic        alu_carryout;
   logic [32:0] alu_sum;

   int errors = 0;
   int checks = 0;

   mips_divider #(.WIDTH(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .is_signed     (is_signed),
      .dividend      (dividend),
      .divisor       (divisor),
      .busy          (busy),
      .done          (done),
      .div_by_zero   (div_by_zero),
      .quotient      (quotient),
      .remainder     (remainder),
      .alu_command   (alu_command),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_result    (alu_result),
      .alu_carryout  (alu_carryout)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (alu_command == 3'd1) alu_sum = {1'b0, alu_operand_a} + {1'b0, ~alu_operand_b} + 33'd1;
      else                     alu_sum = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
      alu_result   = alu_sum[31:0];
      alu_carryout = alu_sum[32];
   end

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
      end
      checks++;
      if (quotient !== 32'h0 || remainder !== 32'h0) begin
         errors++; $display("FAIL reset_results: got q=%h r=%h want 0/0", quotient, remainder);
      end
      checks++;
      if (alu_command !== 3'd0 || alu_operand_a !== 32'h0 || alu_operand_b !== 32'h0) begin
         errors++; $display("FAIL reset_alu: got cmd=%0d a=%h b=%h want 0/0/0",
                            alu_command, alu_operand_a, alu_operand_b);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Launch one division, follow it to done, then check latency, busy window and results.
   task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      int done_at;
      int busy_bad;
      done_at = -1; busy_bad = 0;
      @(negedge clk);
      start = 1'b1; is_signed = s; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 45 && done_at < 0; k++) begin
         if (done) done_at = k;
         else begin
            if (!busy) busy_bad++;
            @(negedge clk);
         end
      end
      checks++;
      if (done_at !== 37) begin
         errors++; $display("FAIL %s_latency: done at cycle %0d want 37", name, done_at);
      end
      checks++;
      if (busy_bad !== 0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s_busy: low-before-done=%0d busy-at-done=%b want 0/0", name, busy_bad, busy);
      end
      checks++;
      if (quotient !== eq) begin
         errors++; $display("FAIL %s_quotient: got %h want %h", name, quotient, eq);
      end
      checks++;
      if (remainder !== er) begin
         errors++; $display("FAIL %s_remainder: got %h want %h", name, remainder, er);
      end
      checks++;
      if (div_by_zero !== edbz) begin
         errors++; $display("FAIL %s_dbz: got %b want %b", name, div_by_zero, edbz);
      end
   endtask

   task automatic test_divu_basic();
      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
         errors++; $display("FAIL done_pulse_hold: got done=%b q=%h r=%h want 0/e/2", done, quotient, remainder);
      end
   endtask

   task automatic test_signed();
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
      run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
   endtask

   task automatic test_unsigned_edges();
      run_div("divu_max_maxm1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0);
      run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
   endtask

   task automatic test_div_by_zero();
      run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1);
   endtask

   task automatic test_ignore_start();
      int done_at;
      int ndone;
      done_at = -1; ndone = 0;
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      for (int k = 1; k <= 45; k++) begin
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = k;
         end
         if (done_at < 0) begin
            start = (k == 5 || k == 20);
            dividend = 32'd50; divisor = 32'd5;
         end else start = 1'b0;
         if (done && (quotient !== 32'd14 || remainder !== 32'd2)) begin
            errors++; $display("FAIL ignore_result: got q=%h r=%h want e/2", quotient, remainder);
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (ndone !== 1 || done_at !== 37) begin
         errors++; $display("FAIL ignore_start: dones=%0d first at %0d want 1 at 37", ndone, done_at);
      end
   endtask

   task automatic test_back_to_back();
      int first_at;
      int second_at;
      logic busy38;
      first_at = -1; second_at = -1; busy38 = 1'b0;
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 80 && second_at < 0; k++) begin
         if (k == 38) busy38 = busy;
         if (done && first_at < 0) begin
            first_at = k;
            checks++;
            if (quotient !== 32'd14 || remainder !== 32'd2) begin
               errors++; $display("FAIL b2b_first: got q=%h r=%h want e/2", quotient, remainder);
            end
            start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
         end else if (done) begin
            second_at = k;
         end else begin
            start = 1'b0;
         end
         if (second_at < 0) @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (first_at !== 37 || second_at !== 74 || busy38 !== 1'b1) begin
         errors++; $display("FAIL b2b_timing: done at %0d/%0d busy38=%b want 37/74/1", first_at, second_at, busy38);
      end
      checks++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
         errors++; $display("FAIL b2b_second: got q=%h r=%h want ffffffff/0", quotient, remainder);
      end
   endtask

   task automatic test_reset_mid();
      int spurious;
      spurious = 0;
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'h0 || remainder !== 32'h0) begin
         errors++; $display("FAIL reset_mid_outputs: got flags=%b q=%h r=%h want 000/0/0",
                            {busy, done, div_by_zero}, quotient, remainder);
      end
      checks++;
      if (alu_command !== 3'd0 || alu_operand_a !== 32'h0 || alu_operand_b !== 32'h0) begin
         errors++; $display("FAIL reset_mid_alu: got cmd=%0d a=%h b=%h want 0/0/0",
                            alu_command, alu_operand_a, alu_operand_b);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) spurious++;
      end
      checks++;
      if (spurious !== 0) begin
         errors++; $display("FAIL reset_mid_no_done: active cycles=%0d want 0", spurious);
      end
      run_div("after_reset_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_unsigned_edges();
      test_div_by_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
